// File: rtl/mp_add_pkg.sv
// Shared constants and FSM state type for the multi-precision add/subtract controller.
package mp_add_pkg;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t;
endpackage

// File: rtl/select_adder.sv
// 16-bit carry-select adder: low byte ripples, high byte is precomputed for both carry-ins.
module select_adder
    import mp_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              ci,
    output logic [WORD_W-1:0] sum,
    output logic              co
);
    localparam int HALF = WORD_W / 2;

    logic [HALF:0] lo;
    logic [HALF:0] hi0;
    logic [HALF:0] hi1;

    always_comb begin
        lo  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, ci};
        hi0 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]};
        hi1 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};
        // Low-half carry picks which precomputed upper half is used.
        if (lo[HALF]) begin
            sum = {hi1[HALF-1:0], lo[HALF-1:0]};
            co  = hi1[HALF];
        end else begin
            sum = {hi0[HALF-1:0], lo[HALF-1:0]};
            co  = hi0[HALF];
        end
    end
endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision add/subtract, one 16-bit word per cycle through a single select_adder.
// Optional signed-overflow output enabled by defining MP_ADD_OVF_EN.
module mp_add_ctrl
    import mp_add_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [WORD_W*WORDS-1:0] A,
    input  logic [WORD_W*WORDS-1:0] B,
    input  logic                    sub,
    input  logic                    cin,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WORD_W*WORDS-1:0] S,
    output logic                    cout,
`ifdef MP_ADD_OVF_EN
    output logic                    ovf,
`endif
    output logic                    busy,
    output mp_state_t               dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // start_ready is high only in IDLE and res_valid only in DONE, so the two never overlap.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    mp_state_t state, state_nxt;

    logic [WORDS-1:0][WORD_W-1:0] a_q, b_q, s_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         carry_q;
    logic                         cout_q;
    logic                         start_fire;
    logic                         last_word;
    logic [WORD_W-1:0]            add_sum;
    logic                         add_co;
`ifdef MP_ADD_OVF_EN
    logic                         ovf_q;
`endif

    select_adder u_add (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .ci  (carry_q),
        .sum (add_sum),
        .co  (add_co)
    );

    assign start_ready = (state == IDLE) && !Reset;
    assign start_fire  = start_valid && start_ready;
    assign last_word   = (idx_q == IDX_W'(WORDS - 1));
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign S           = s_q;
    assign cout        = cout_q;
    assign dbg_state   = state;
`ifdef MP_ADD_OVF_EN
    assign ovf         = ovf_q;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_fire) state_nxt = RUN;
            RUN:     if (last_word)  state_nxt = DONE;
            DONE:    if (res_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef MP_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (start_fire) begin
                // Subtraction is A + ~B + 1: invert B once here and seed the carry.
                a_q     <= A;
                b_q     <= sub ? ~B : B;
                carry_q <= sub ? 1'b1 : cin;
                idx_q   <= '0;
            end
        end else if (state == RUN) begin
            s_q[idx_q] <= add_sum;
            carry_q    <= add_co;
            idx_q      <= idx_q + 1'b1;
            if (last_word) begin
                cout_q <= add_co;
`ifdef MP_ADD_OVF_EN
                ovf_q  <= (a_q[WORDS-1][WORD_W-1] == b_q[WORDS-1][WORD_W-1]) &&
                          (add_sum[WORD_W-1] != a_q[WORDS-1][WORD_W-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_mp_add_ctrl.sv
// Directed self-checking bench for mp_add_ctrl with WORDS=2 (ovf checks when MP_ADD_OVF_EN is defined).
module tb_mp_add_ctrl;
    import mp_add_pkg::*;

    localparam int WORDS = 2;
    localparam int W     = WORD_W * WORDS;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] A, B;
    logic         sub, cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] S;
    logic         cout;
    logic         busy;
    mp_state_t    dbg_state;
`ifdef MP_ADD_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // Expected {ovf, cout, S} per operation.
    logic [W+1:0] exp_q[$];

    mp_add_ctrl #(.WORDS(WORDS)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .sub         (sub),
        .cin         (cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .S           (S),
        .cout        (cout),
`ifdef MP_ADD_OVF_EN
        .ovf         (ovf),
`endif
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge Clk);
        check_val("start_ready_idle", start_ready, 1);
        exp_q.push_back({eo, ec, es});
        A = a; B = b; sub = s; cin = c; start_valid = 1'b1;
        @(posedge Clk);
    endtask

    // Call right after the accept edge; leaves the bench at a negedge with DONE held.
    task automatic wait_result();
        logic [W+1:0] e;
        int lat;
        lat = 0;
        @(negedge Clk);
        start_valid = 1'b0;
        A = '1; B = '1;
        while (res_valid !== 1'b1 && lat < 20) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        check_val("latency", lat, WORDS);
        e = exp_q.pop_front();
        check_val("sum", S, e[W-1:0]);
        check_val("cout", cout, e[W]);
`ifdef MP_ADD_OVF_EN
        check_val("ovf", ovf, e[W+1]);
`endif
        check_val("busy_done", busy, 1);
        check_val("start_ready_done", start_ready, 0);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        res_ready = 1'b0;
        check_val("res_valid_drop", res_valid, 0);
        check_val("state_idle", dbg_state, IDLE);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        issue(a, b, s, c, es, ec, eo);
        wait_result();
        release_result();
    endtask

    initial begin
        Reset = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        A = '0; B = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(negedge Clk);
        check_val("rst_S", S, 0);
        check_val("rst_cout", cout, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_busy", busy, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check_val("rst_start_ready", start_ready, 1);
        check_val("rst_state", dbg_state, IDLE);

        do_op(32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 0, 0);
        do_op(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0);
        do_op(32'hFFFFFFFF, 32'h00000000, 0, 1, 32'h00000000, 1, 0);
        do_op(32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0);
        do_op(32'h00000007, 32'h00000005, 1, 0, 32'h00000002, 1, 0);
`ifdef MP_ADD_OVF_EN
        do_op(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1);
        do_op(32'h80000000, 32'h00000001, 1, 0, 32'h7FFFFFFF, 1, 1);
`endif

        // Backpressure: result held while a new request waits.
        issue(32'h00000001, 32'h00000002, 0, 0, 32'h00000003, 0, 0);
        wait_result();
        exp_q.push_back({1'b0, 1'b0, 32'h0001FFFF});
        A = 32'h00010000; B = 32'h0000FFFF; sub = 1'b0; cin = 1'b0; start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check_val("bp_S", S, 32'h00000003);
            check_val("bp_cout", cout, 0);
            check_val("bp_res_valid", res_valid, 1);
            check_val("bp_start_ready", start_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        res_ready = 1'b0;
        check_val("bp_res_valid_drop", res_valid, 0);
        check_val("bp_start_ready_idle", start_ready, 1);
        @(posedge Clk);
        wait_result();
        release_result();

        // Reset one cycle into RUN.
        issue(32'hAAAA5555, 32'h11111111, 0, 0, 32'h0, 0, 0);
        void'(exp_q.pop_back());
        @(negedge Clk);
        start_valid = 1'b0;
        check_val("pre_rst_state", dbg_state, RUN);
        Reset = 1'b1;
        #1;
        check_val("mid_rst_S", S, 0);
        check_val("mid_rst_cout", cout, 0);
        check_val("mid_rst_res_valid", res_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_val("post_rst_start_ready", start_ready, 1);
        do_op(32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: got no end expected end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
